mc_maindec: RTL and testbench
=============================

# mc_maindec

Parametrised multicycle main control FSM for the MIPS datapath, successor to the fixed-latency decoder. It decodes the 6-bit opcode, sequences the IF/ID/EX/MEM/WB states and drives every datapath control strobe. It adds two things: a request/ready memory handshake so fetch and data-memory states stretch across wait cycles, and a datapath-width parameter that makes the 64-bit opcodes legal or illegal. It sits between the instruction register opcode field and the datapath, replacing the existing main decoder one-for-one on all shared outputs.

## Interface
- `XLEN`, 64: datapath width, 32 or 64. At 32, LD/SD/DADDI are illegal opcodes.
- `TIMEOUT`, 255: maximum consecutive wait cycles in one memory state before a timeout trap. Used only with the trap feature; minimum 1.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 6: opcode field of the instruction register.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request, asserted in IF and all MEM_* states.
- `pcwrite`, `irwrite`, `regwrite`, `branch`, `bne`, `iord`, `memtoreg`, `regdst`, `alusrca`, `dtype` out 1 each: datapath strobes and selects.
- `memwrite` out 2: 00 none, 01 word, 10 byte, 11 doubleword.
- `alusrcb` out 3, `pcsrc` out 2, `aluop` out 3, `ltype` out 2: datapath selects.
- `stateshow` out 5: current state encoding.
- `trap` out 1: sticky fault flag. Present only with `MC_MAINDEC_TRAP_EN`.
- `trap_cause` out 2: 01 illegal opcode, 10 memory timeout. Present only with `MC_MAINDEC_TRAP_EN`.

## Operation
- State encodings 0–21, in this order: IF, ID, EX_LS, MEM_LW, WB_L, MEM_SW, EX_RTYPE, WB_RTYPE, EX_BEQ, EX_ADDI, EX_J, EX_ANDI, EX_BNE, MEM_LBU, MEM_LB, EX_ORI, EX_SLTI, MEM_SB, WB_I, MEM_LD, MEM_SD, EX_DADDI. TRAP is 22.
- Opcodes:
  - RTYPE 000000, LD 110111, LW 100011, LBU 100100, LB 100000.
  - SD 111111, SW 101011, SB 101000.
  - BEQ 000100, BNE 000101, J 000010.
  - ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, DADDI 011000.
- Transitions:
  - IF→ID.
  - ID dispatches on `op`: loads and stores → EX_LS; others → their own EX_* state.
  - EX_LS→MEM_<op>.
  - MEM loads→WB_L; MEM stores→IF.
  - EX_RTYPE→WB_RTYPE→IF.
  - EX_BEQ, EX_BNE, EX_J→IF.
  - EX_ADDI, EX_ANDI, EX_ORI, EX_SLTI, EX_DADDI→WB_I→IF.
  - WB_L→IF.
- Wait states: IF and all MEM_* states hold while `mem_ready`=0 and advance on the cycle `mem_ready`=1.
- In IF, `pcwrite` and `irwrite` are asserted only in the cycle `mem_ready`=1, so the PC advances exactly once per fetch.
- Store states drive `memwrite` for the whole state. Memory commits the write on the ready cycle.
- Control values per state are bit-identical to the existing decoder. Key values:
  - IF: `alusrcb`=001.
  - ID: `alusrcb`=011.
  - EX_LS: `alusrca`=1, `alusrcb`=010.
  - MEM_*: `iord`=1; `ltype` LD 00/`dtype`=1, LB 10, LBU 01.
  - `memwrite`: SD 11, SW 01, SB 10.
  - WB_L: `regwrite`=1, `memtoreg`=1.
  - EX_RTYPE: `aluop`=010. WB_RTYPE: `regdst`=1, `regwrite`=1.
  - EX_BEQ: `branch`=1. EX_BNE: `bne`=1. Both `pcsrc`=01, `aluop`=001.
  - EX_J: `pcwrite`=1, `pcsrc`=10.
  - EX_ANDI and EX_ORI: `alusrcb`=100, `aluop` 011 / 100.
  - EX_SLTI and EX_DADDI: `alusrcb`=010, `aluop` 101 / 110.
  - WB_I: `regwrite`=1.
- All outputs not listed for a state are 0.
- Illegal opcode in ID, or in EX_LS: next state IF (without the trap feature).

## Timing
- `reset_n` low: state=IF immediately (asynchronous). While held low, `mem_req`, `pcwrite`, `irwrite` and every other strobe are forced 0; `stateshow`=0.
- Reset may be asserted mid-access. Any partially waited MEM state is abandoned and no write strobe survives.
- Latency with zero wait (`mem_ready` tied 1):
  - R-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch and jump: 3 cycles.
  - I-type ALU: 4 cycles.
- Each cycle `mem_ready` is low in IF or a MEM state adds one cycle.
- `mem_ready` asserted outside IF/MEM states is ignored.
- The state register is the only clocked element, plus the wait counter when traps are compiled in. Outputs decode combinationally from state and `mem_ready`.

## Configuration
- `MC_MAINDEC_TRAP_EN` defined:
  - An illegal opcode in ID → TRAP with `trap_cause`=01.
  - A `$clog2(TIMEOUT+1)`-bit wait counter clears on entry to each IF/MEM state and increments on each `mem_ready`=0 cycle.
  - The counter reaching `TIMEOUT` → TRAP with `trap_cause`=10.
  - In TRAP, all strobes are 0, `trap`=1, and the state is held until reset.
  - `mem_ready`=1 in the same cycle the counter hits `TIMEOUT` completes the access normally; no trap.
- `MC_MAINDEC_TRAP_EN` undefined: no counter and no `trap`/`trap_cause` ports. Illegal opcodes return to IF and wait states are unbounded.

## Structure
- Shared package `mc_ctrl_pkg`: the `statetype` enum, the opcode constants, the `memwrite`/`ltype` encodings and the `trap_cause` encodings. The datapath and the bench import it.
- One sub-module, `mc_wait_timer`: the wait counter and timeout compare. It is instantiated only under the macro.

## Test plan
- `mem_ready`=1, `op`=ADD (000000) → `stateshow` 0,1,6,7,0; `regwrite`=1 and `regdst`=1 only in cycle 4.
- `op`=LW with `mem_ready` low for 3 cycles in MEM_LW → the state holds at 3 for 4 cycles, `mem_req`=1 throughout, then WB_L; `pcwrite` pulses exactly once during IF.
- `op`=SB, `mem_ready`=1 → `memwrite`=10 and `iord`=1 in state 17; next state is 0.
- `XLEN`=32, `op`=LD:
  - with the macro: TRAP, `trap_cause`=01;
  - without the macro: ID→IF and no strobes.
- Macro on, `TIMEOUT`=4, `mem_ready` held 0 in IF → TRAP after 4 wait cycles, `trap_cause`=10; a repeat with ready rising on the 4th wait cycle → ID, no trap.
- `reset_n` pulled low in MEM_SD with `memwrite`=11 → `memwrite` is 0 in the same cycle; after release the FSM restarts at IF.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared control package for the multicycle MIPS main decoder.
// Holds the state enum, opcode constants, memwrite/ltype/trap_cause encodings,
// the packed control word, and small helpers used by the decoder.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        IF, ID, EX_LS, MEM_LW, WB_L, MEM_SW, EX_RTYPE, WB_RTYPE, EX_BEQ, EX_ADDI,
        EX_J, EX_ANDI, EX_BNE, MEM_LBU, MEM_LB, EX_ORI, EX_SLTI, MEM_SB, WB_I,
        MEM_LD, MEM_SD, EX_DADDI, TRAP
    } statetype;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LD    = 6'b110111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SD    = 6'b111111;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_DADDI = 6'b011000;

    localparam logic [1:0] MW_NONE  = 2'b00;
    localparam logic [1:0] MW_WORD  = 2'b01;
    localparam logic [1:0] MW_BYTE  = 2'b10;
    localparam logic [1:0] MW_DWORD = 2'b11;

    // Word and doubleword loads share ltype 00; dtype tells them apart.
    localparam logic [1:0] LT_WORD  = 2'b00;
    localparam logic [1:0] LT_BYTEU = 2'b01;
    localparam logic [1:0] LT_BYTE  = 2'b10;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       pcwrite;
        logic       irwrite;
        logic       regwrite;
        logic       branch;
        logic       bne;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic       dtype;
        logic [1:0] memwrite;
        logic [2:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic [1:0] ltype;
    } ctl_t;

    // 64-bit opcodes only decode on a 64-bit datapath.
    function automatic logic op_legal(input logic [5:0] op, input int xlen);
        case (op)
            OP_RTYPE, OP_LW, OP_LBU, OP_LB, OP_SW, OP_SB, OP_BEQ, OP_BNE, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: op_legal = 1'b1;
            OP_LD, OP_SD, OP_DADDI:            op_legal = (xlen >= 64);
            default:                           op_legal = 1'b0;
        endcase
    endfunction

    // States that stall on the memory handshake.
    function automatic logic is_wait_state(input statetype s);
        case (s)
            IF, MEM_LW, MEM_LBU, MEM_LB, MEM_LD,
            MEM_SW, MEM_SB, MEM_SD: is_wait_state = 1'b1;
            default:                is_wait_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Wait-cycle counter for memory-stalled states.
// Ports: clk, reset_n (async low); wait_st (FSM in IF/MEM), mem_ready,
// hold (FSM trapped: freeze count so it records the trap cause);
// timeout (this cycle is the TIMEOUT-th consecutive wait), at_max (count == TIMEOUT).
module mc_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic wait_st,
    input  logic mem_ready,
    input  logic hold,
    output logic timeout,
    output logic at_max
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAXC = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    // Wait states only ever exit on mem_ready=1, so clearing on ready or on any
    // non-wait state guarantees a zero count on entry to every IF/MEM state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 cnt <= '0;
        else if (hold)                cnt <= cnt;
        else if (!wait_st || mem_ready) cnt <= '0;
        else                          cnt <= cnt + 1'b1;
    end

    // Ready in the same cycle completes the access instead of trapping.
    assign timeout = wait_st && !mem_ready && (cnt == LAST);
    assign at_max  = (cnt == MAXC);

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM with request/ready memory handshake.
// Params: XLEN (32/64; LD/SD/DADDI illegal at 32), TIMEOUT (max wait cycles, trap build only).
// Ports: clk, reset_n (async low), op, mem_ready in; mem_req, datapath strobes/selects,
// stateshow out; trap, trap_cause out only when MC_MAINDEC_TRAP_EN is defined.
// MC_MAINDEC_TRAP_EN: illegal opcodes and memory timeouts enter a sticky TRAP state.
module mc_maindec
    import mc_ctrl_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       branch,
    output logic       bne,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic       dtype,
    output logic [1:0] memwrite,
    output logic [2:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic [1:0] ltype,
`ifdef MC_MAINDEC_TRAP_EN
    output logic       trap,
    output logic [1:0] trap_cause,
`endif
    output logic [4:0] stateshow
);

    statetype state, state_nxt;
    ctl_t     ctl;
    logic     legal, wait_st;

    assign legal   = op_legal(op, XLEN);
    assign wait_st = is_wait_state(state);

`ifdef MC_MAINDEC_TRAP_EN
    localparam statetype BAD_OP_NXT = TRAP;
    logic timeout, at_max;

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .wait_st   (wait_st),
        .mem_ready (mem_ready),
        .hold      (state == TRAP),
        .timeout   (timeout),
        .at_max    (at_max)
    );

    // The frozen counter tells the two causes apart: an illegal opcode traps
    // from ID with the count cleared, a timeout traps with it at TIMEOUT.
    assign trap       = (state == TRAP);
    assign trap_cause = !trap ? TC_NONE : (at_max ? TC_TIMEOUT : TC_ILLEGAL);
`else
    localparam statetype BAD_OP_NXT = IF;
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IF;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IF:       if (mem_ready) state_nxt = ID;
            ID: begin
                if (!legal) state_nxt = BAD_OP_NXT;
                else case (op)
                    OP_LW, OP_LBU, OP_LB, OP_LD,
                    OP_SW, OP_SB, OP_SD: state_nxt = EX_LS;
                    OP_RTYPE:            state_nxt = EX_RTYPE;
                    OP_BEQ:              state_nxt = EX_BEQ;
                    OP_BNE:              state_nxt = EX_BNE;
                    OP_J:                state_nxt = EX_J;
                    OP_ADDI:             state_nxt = EX_ADDI;
                    OP_ANDI:             state_nxt = EX_ANDI;
                    OP_ORI:              state_nxt = EX_ORI;
                    OP_SLTI:             state_nxt = EX_SLTI;
                    OP_DADDI:            state_nxt = EX_DADDI;
                    default:             state_nxt = BAD_OP_NXT;
                endcase
            end
            EX_LS: begin
                state_nxt = IF;
                if (legal) case (op)
                    OP_LW:   state_nxt = MEM_LW;
                    OP_LBU:  state_nxt = MEM_LBU;
                    OP_LB:   state_nxt = MEM_LB;
                    OP_LD:   state_nxt = MEM_LD;
                    OP_SW:   state_nxt = MEM_SW;
                    OP_SB:   state_nxt = MEM_SB;
                    OP_SD:   state_nxt = MEM_SD;
                    default: state_nxt = IF;
                endcase
            end
            MEM_LW, MEM_LBU, MEM_LB, MEM_LD: if (mem_ready) state_nxt = WB_L;
            MEM_SW, MEM_SB, MEM_SD:          if (mem_ready) state_nxt = IF;
            EX_RTYPE:                         state_nxt = WB_RTYPE;
            EX_ADDI, EX_ANDI, EX_ORI,
            EX_SLTI, EX_DADDI:                state_nxt = WB_I;
            TRAP:                             state_nxt = TRAP;
            default:                          state_nxt = IF;
        endcase
`ifdef MC_MAINDEC_TRAP_EN
        if (timeout) state_nxt = TRAP;
`endif
    end

    always_comb begin
        ctl = '0;
        case (state)
            IF: begin
                ctl.mem_req = 1'b1;
                ctl.alusrcb = 3'b001;
                // Fetch commits once, on the ready cycle.
                ctl.pcwrite = mem_ready;
                ctl.irwrite = mem_ready;
            end
            ID:      ctl.alusrcb = 3'b011;
            EX_LS:   begin ctl.alusrca = 1'b1; ctl.alusrcb = 3'b010; end
            MEM_LW:  begin ctl.mem_req = 1'b1; ctl.iord = 1'b1; ctl.ltype = LT_WORD; end
            MEM_LD:  begin ctl.mem_req = 1'b1; ctl.iord = 1'b1; ctl.ltype = LT_WORD; ctl.dtype = 1'b1; end
            MEM_LB:  begin ctl.mem_req = 1'b1; ctl.iord = 1'b1; ctl.ltype = LT_BYTE; end
            MEM_LBU: begin ctl.mem_req = 1'b1; ctl.iord = 1'b1; ctl.ltype = LT_BYTEU; end
            MEM_SW:  begin ctl.mem_req = 1'b1; ctl.iord = 1'b1; ctl.memwrite = MW_WORD; end
            MEM_SB:  begin ctl.mem_req = 1'b1; ctl.iord = 1'b1; ctl.memwrite = MW_BYTE; end
            MEM_SD:  begin ctl.mem_req = 1'b1; ctl.iord = 1'b1; ctl.memwrite = MW_DWORD; end
            WB_L:    begin ctl.regwrite = 1'b1; ctl.memtoreg = 1'b1; end
            EX_RTYPE: ctl.aluop = 3'b010;
            WB_RTYPE: begin ctl.regdst = 1'b1; ctl.regwrite = 1'b1; end
            EX_BEQ:  begin ctl.branch = 1'b1; ctl.pcsrc = 2'b01; ctl.aluop = 3'b001; end
            EX_BNE:  begin ctl.bne = 1'b1; ctl.pcsrc = 2'b01; ctl.aluop = 3'b001; end
            EX_J:    begin ctl.pcwrite = 1'b1; ctl.pcsrc = 2'b10; end
            EX_ANDI: begin ctl.alusrcb = 3'b100; ctl.aluop = 3'b011; end
            EX_ORI:  begin ctl.alusrcb = 3'b100; ctl.aluop = 3'b100; end
            EX_SLTI: begin ctl.alusrcb = 3'b010; ctl.aluop = 3'b101; end
            EX_DADDI: begin ctl.alusrcb = 3'b010; ctl.aluop = 3'b110; end
            WB_I:    ctl.regwrite = 1'b1;
            default: ctl = '0;
        endcase
        // Reset kills every strobe at once, including a store mid-access.
        if (!reset_n) ctl = '0;
    end

    assign mem_req   = ctl.mem_req;
    assign pcwrite   = ctl.pcwrite;
    assign irwrite   = ctl.irwrite;
    assign regwrite  = ctl.regwrite;
    assign branch    = ctl.branch;
    assign bne       = ctl.bne;
    assign iord      = ctl.iord;
    assign memtoreg  = ctl.memtoreg;
    assign regdst    = ctl.regdst;
    assign alusrca   = ctl.alusrca;
    assign dtype     = ctl.dtype;
    assign memwrite  = ctl.memwrite;
    assign alusrcb   = ctl.alusrcb;
    assign pcsrc     = ctl.pcsrc;
    assign aluop     = ctl.aluop;
    assign ltype     = ctl.ltype;
    assign stateshow = reset_n ? 5'(state) : 5'd0;

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: a 64-bit and a 32-bit instance run side by side, each
// tracked by an instruction-level model (per-opcode phase list plus wait count).
module tb_mc_maindec;
    import mc_ctrl_pkg::*;

    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0][5:0] opv = '0;
    logic [1:0]      rdy = '0;

    logic [1:0]      mem_req, pcwrite, irwrite, regwrite, branch, bne, iord;
    logic [1:0]      memtoreg, regdst, alusrca, dtype;
    logic [1:0][1:0] memwrite, pcsrc, ltype;
    logic [1:0][2:0] alusrcb, aluop;
    logic [1:0][4:0] stateshow;
    ctl_t [1:0]      obs;
`ifdef MC_MAINDEC_TRAP_EN
    logic [1:0]      trap;
    logic [1:0][1:0] trap_cause;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mc_maindec #(.XLEN(g == 0 ? 64 : 32), .TIMEOUT(TO)) u_dut (
            .clk(clk), .reset_n(reset_n), .op(opv[g]), .mem_ready(rdy[g]),
            .mem_req(mem_req[g]), .pcwrite(pcwrite[g]), .irwrite(irwrite[g]),
            .regwrite(regwrite[g]), .branch(branch[g]), .bne(bne[g]), .iord(iord[g]),
            .memtoreg(memtoreg[g]), .regdst(regdst[g]), .alusrca(alusrca[g]),
            .dtype(dtype[g]), .memwrite(memwrite[g]), .alusrcb(alusrcb[g]),
            .pcsrc(pcsrc[g]), .aluop(aluop[g]), .ltype(ltype[g]),
`ifdef MC_MAINDEC_TRAP_EN
            .trap(trap[g]), .trap_cause(trap_cause[g]),
`endif
            .stateshow(stateshow[g])
        );
        assign obs[g] = {mem_req[g], pcwrite[g], irwrite[g], regwrite[g], branch[g],
                         bne[g], iord[g], memtoreg[g], regdst[g], alusrca[g], dtype[g],
                         memwrite[g], alusrcb[g], pcsrc[g], aluop[g], ltype[g]};
    end

    int nchk = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [5:0] ops [16] = '{OP_RTYPE, OP_LD, OP_LW, OP_LBU, OP_LB, OP_SD, OP_SW, OP_SB,
                             OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_DADDI};
    int       xl   [2] = '{64, 32};
    statetype seq  [2][6];
    int       len  [2], idx [2], wc [2], tr [2];   // tr: 0 run, 1 illegal trap, 2 timeout trap
    bit       done [2];
    int       npcw [2], nlw [2], nrw [2];

    function automatic bit legal(input logic [5:0] o, input int x);
        bit known = 0;
        foreach (ops[k]) if (ops[k] == o) known = 1;
        if (x == 32 && (o == OP_LD || o == OP_SD || o == OP_DADDI)) known = 0;
        return known;
    endfunction

    function automatic bit memphase(input statetype s);
        return s inside {IF, MEM_LW, MEM_LBU, MEM_LB, MEM_LD, MEM_SW, MEM_SB, MEM_SD};
    endfunction

    // Expected strobes, one signal at a time from the per-state control list.
    function automatic ctl_t exp_ctl(input statetype s, input logic r);
        ctl_t c = '0;
        c.mem_req  = memphase(s);
        c.iord     = memphase(s) && s != IF;
        c.pcwrite  = (s == IF && r) || s == EX_J;
        c.irwrite  = (s == IF && r);
        c.regwrite = s inside {WB_L, WB_RTYPE, WB_I};
        c.branch   = (s == EX_BEQ);
        c.bne      = (s == EX_BNE);
        c.memtoreg = (s == WB_L);
        c.regdst   = (s == WB_RTYPE);
        c.alusrca  = (s == EX_LS);
        c.dtype    = (s == MEM_LD);
        c.memwrite = (s == MEM_SD) ? 2'd3 : (s == MEM_SW) ? 2'd1 : (s == MEM_SB) ? 2'd2 : 2'd0;
        c.alusrcb  = (s == IF) ? 3'd1 : (s == ID) ? 3'd3 :
                     (s inside {EX_LS, EX_SLTI, EX_DADDI}) ? 3'd2 :
                     (s inside {EX_ANDI, EX_ORI}) ? 3'd4 : 3'd0;
        c.pcsrc    = (s inside {EX_BEQ, EX_BNE}) ? 2'd1 : (s == EX_J) ? 2'd2 : 2'd0;
        c.aluop    = (s == EX_RTYPE) ? 3'd2 : (s inside {EX_BEQ, EX_BNE}) ? 3'd1 :
                     (s == EX_ANDI) ? 3'd3 : (s == EX_ORI) ? 3'd4 :
                     (s == EX_SLTI) ? 3'd5 : (s == EX_DADDI) ? 3'd6 : 3'd0;
        c.ltype    = (s == MEM_LB) ? 2'd2 : (s == MEM_LBU) ? 2'd1 : 2'd0;
        return c;
    endfunction

    task automatic load(input int i, input logic [5:0] o);
        int n = 2;
        opv[i] = o;
        seq[i][0] = IF;
        seq[i][1] = ID;
        if (!legal(o, xl[i])) begin
`ifdef MC_MAINDEC_TRAP_EN
            seq[i][2] = TRAP; n = 3;
`endif
        end else case (o)
            OP_RTYPE: begin seq[i][2] = EX_RTYPE; seq[i][3] = WB_RTYPE; n = 4; end
            OP_LW:    begin seq[i][2] = EX_LS; seq[i][3] = MEM_LW;  seq[i][4] = WB_L; n = 5; end
            OP_LBU:   begin seq[i][2] = EX_LS; seq[i][3] = MEM_LBU; seq[i][4] = WB_L; n = 5; end
            OP_LB:    begin seq[i][2] = EX_LS; seq[i][3] = MEM_LB;  seq[i][4] = WB_L; n = 5; end
            OP_LD:    begin seq[i][2] = EX_LS; seq[i][3] = MEM_LD;  seq[i][4] = WB_L; n = 5; end
            OP_SW:    begin seq[i][2] = EX_LS; seq[i][3] = MEM_SW; n = 4; end
            OP_SB:    begin seq[i][2] = EX_LS; seq[i][3] = MEM_SB; n = 4; end
            OP_SD:    begin seq[i][2] = EX_LS; seq[i][3] = MEM_SD; n = 4; end
            OP_BEQ:   begin seq[i][2] = EX_BEQ; n = 3; end
            OP_BNE:   begin seq[i][2] = EX_BNE; n = 3; end
            OP_J:     begin seq[i][2] = EX_J;   n = 3; end
            OP_ADDI:  begin seq[i][2] = EX_ADDI;  seq[i][3] = WB_I; n = 4; end
            OP_ANDI:  begin seq[i][2] = EX_ANDI;  seq[i][3] = WB_I; n = 4; end
            OP_ORI:   begin seq[i][2] = EX_ORI;   seq[i][3] = WB_I; n = 4; end
            OP_SLTI:  begin seq[i][2] = EX_SLTI;  seq[i][3] = WB_I; n = 4; end
            default:  begin seq[i][2] = EX_DADDI; seq[i][3] = WB_I; n = 4; end
        endcase
        len[i] = n; idx[i] = 0; wc[i] = 0; tr[i] = 0; done[i] = 0;
    endtask

    function automatic statetype cur(input int i);
        return (tr[i] != 0) ? TRAP : seq[i][idx[i]];
    endfunction

    task automatic advance(input int i, input logic r);
        if (tr[i] != 0) return;
        if (memphase(seq[i][idx[i]]) && !r) begin
            wc[i]++;
`ifdef MC_MAINDEC_TRAP_EN
            if (wc[i] == TO) tr[i] = 2;
`endif
        end else begin
            wc[i] = 0;
            idx[i]++;
            if (idx[i] == len[i]) begin idx[i] = 0; done[i] = 1; end
            else if (seq[i][idx[i]] == TRAP) tr[i] = 1;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic check_now();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("state%0d", i), 32'(stateshow[i]), 32'(cur(i)));
            chk($sformatf("ctl%0d_s%0d", i, cur(i)), 32'(obs[i]), 32'(exp_ctl(cur(i), rdy[i])));
`ifdef MC_MAINDEC_TRAP_EN
            chk($sformatf("trap%0d", i), 32'(trap[i]), 32'(tr[i] != 0));
            chk($sformatf("tcause%0d", i), 32'(trap_cause[i]), 32'(tr[i]));
`endif
            npcw[i] += int'(pcwrite[i]);
            nrw[i]  += int'(regwrite[i]);
            nlw[i]  += int'(stateshow[i] == 5'd3);
        end
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic cycle(input logic r0, input logic r1);
        rdy = {r1, r0};
        #1 check_now();
        @(posedge clk);
        advance(0, r0);
        advance(1, r1);
        @(negedge clk);
    endtask

    task automatic check_rst(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_st%0d", tag, i), 32'(stateshow[i]), 32'd0);
            chk($sformatf("%s_ctl%0d", tag, i), 32'(obs[i]), 32'd0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            idx[i] = 0; wc[i] = 0; tr[i] = 0; done[i] = 0;
            npcw[i] = 0; nlw[i] = 0; nrw[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rdy = 2'b11;
        #1 check_rst("rst");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // One instruction on both instances; instance 0 waits nw cycles in state ws.
    task automatic run(input logic [5:0] o, input statetype ws, input int nw);
        logic r;
        bit fin = 0;
        do_reset();
        load(0, o);
        load(1, o);
        for (int k = 0; k < 40 && !fin; k++) begin
            r = !(cur(0) == ws && wc[0] < nw);
            cycle(r, r);
            fin = done[0] || tr[0] != 0;
        end
        chk("budget", 32'(fin), 32'd1);
    endtask

    task automatic pick(input int i);
        logic [5:0] o;
        bit ok = 0;
        while (!ok) begin
            o = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 15)];
`ifdef MC_MAINDEC_TRAP_EN
            ok = legal(o, xl[i]);
`else
            ok = 1;
`endif
        end
        load(i, o);
    endtask

    initial begin
        @(negedge clk);
        check_rst("por");

        // R-type, zero wait: 0,1,6,7,0 and a single register write.
        run(OP_RTYPE, IF, 0);
        chk("add_regwrite", 32'(nrw[0]), 32'd1);

        // LW with 3 wait cycles in MEM_LW.
        run(OP_LW, MEM_LW, 3);
        chk("lw_memlw_cycles", 32'(nlw[0]), 32'd4);
        chk("lw_pcwrite_once", 32'(npcw[0]), 32'd1);

        // SB, then fetch stall in IF with ready, plus the 64-bit opcodes.
        run(OP_SB, IF, 2);
        run(OP_LD, IF, 0);
`ifdef MC_MAINDEC_TRAP_EN
        chk("ld32_cause", 32'(trap_cause[1]), 32'(TC_ILLEGAL));
`endif
        run(OP_DADDI, IF, 1);

        // Fetch stall of TO cycles: timeout trap in trap build, long wait otherwise.
        run(OP_RTYPE, IF, TO);
`ifdef MC_MAINDEC_TRAP_EN
        cycle(1'b1, 1'b1);
        chk("to_cause", 32'(trap_cause[0]), 32'(TC_TIMEOUT));
`endif
        run(OP_RTYPE, IF, TO - 1);

        // Reset asserted while a doubleword store waits in MEM_SD.
        do_reset();
        load(0, OP_SD);
        load(1, OP_SD);
        repeat (3) cycle(1'b1, 1'b1);
        rdy = 2'b00;
        #1 check_now();
        chk("sd_mw_before", 32'(memwrite[0]), 32'd3);
        #1 reset_n = 1'b0;
        #1 chk("sd_mw_rst", 32'(memwrite[0]), 32'd0);
        chk("sd_req_rst", 32'(mem_req[0]), 32'd0);
        chk("sd_st_rst", 32'(stateshow[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (2) cycle(1'b1, 1'b1);

        // Random opcodes and ready patterns, waits kept below the timeout.
        do_reset();
        pick(0);
        pick(1);
        for (int n = 0; n < 600; n++) begin
            logic r [2];
            for (int i = 0; i < 2; i++) begin
                if (done[i]) pick(i);
                r[i] = (memphase(cur(i)) && wc[i] >= TO - 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            cycle(r[0], r[1]);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
